seq_divider: RTL and testbench



---
 rtl/seq_divider_pkg.sv | 19 +
 rtl/seq_divider_div_step.sv | 25 ++
 rtl/seq_divider.sv | 101 ++++++++++
 tb/tb_seq_divider.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package seq_divider_pkg;

    // Counter width for a given dividend width, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int unsigned DefDividendW = 8;
    localparam int unsigned DefDivisorW  = 4;
    localparam int unsigned DefCntW      = cnt_width(DefDividendW);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in a dividend bit, try to subtract the divisor,
// keep the difference if it did not borrow, otherwise restore.
module div_step #(
    parameter int unsigned DIVISOR_W = 4
) (
    input  logic [DIVISOR_W:0]   r,
    input  logic                 q_msb,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   r_next,
    output logic                 q_bit
);

    // One guard bit above the partial remainder turns the borrow into a plain sign bit.
    logic [DIVISOR_W+1:0] shifted;
    logic [DIVISOR_W+1:0] diff;

    // Trial subtraction and restore select.
    always_comb begin
        shifted = {r, q_msb};
        diff    = shifted - {2'b00, divisor};
        q_bit   = ~diff[DIVISOR_W+1];
        r_next  = q_bit ? diff[DIVISOR_W:0] : shifted[DIVISOR_W:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock with a start/busy/done handshake.
// Division by zero completes immediately with an all-ones quotient and a sticky flag.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = DefDividendW,
    parameter int unsigned DIVISOR_W  = DefDivisorW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int unsigned       CntW    = cnt_width(DIVIDEND_W);
    localparam logic [CntW-1:0]   LastCnt = CntW'(DIVIDEND_W - 1);

    state_e                state_q;
    logic [DIVIDEND_W-1:0] q_q;        // dividend in, quotient out, shifting left
    logic [DIVISOR_W:0]    r_q;        // partial remainder
    logic [DIVISOR_W-1:0]  divisor_q;
    logic [CntW-1:0]       cnt_q;

    logic [DIVISOR_W:0]    r_next;
    logic                  q_bit;

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .r       (r_q),
        .q_msb   (q_q[DIVIDEND_W-1]),
        .divisor (divisor_q),
        .r_next  (r_next),
        .q_bit   (q_bit)
    );

    // Results come straight from the working registers; they only move while busy.
    assign quotient  = q_q;
    assign remainder = r_q[DIVISOR_W-1:0];

    // Control FSM and datapath registers; busy/done/div_by_zero are registered with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            q_q         <= '0;
            r_q         <= '0;
            divisor_q   <= '0;
            cnt_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= StIdle;
                    if (start) begin
                        if (divisor != '0) begin
                            state_q     <= StRun;
                            busy        <= 1'b1;
                            div_by_zero <= 1'b0;
                            q_q         <= dividend;
                            r_q         <= '0;
                            divisor_q   <= divisor;
                            cnt_q       <= '0;
                        end else begin
                            state_q     <= StDone;
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                            q_q         <= '1;
                            r_q         <= '0;
                        end
                    end
                end
                StRun: begin
                    r_q   <= r_next;
                    q_q   <= {q_q[DIVIDEND_W-2:0], q_bit};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: arithmetic reference model plus directed and random ops.
module tb_seq_divider;

    localparam int DW = 8;
    localparam int VW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    int tests = 0;
    int fails = 0;

    seq_divider #(
        .DIVIDEND_W (DW),
        .DIVISOR_W  (VW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: cycles-left countdown plus plain integer division.
    bit model_ok = 1'b0;
    int m_left = 0;
    int m_busy, m_done, m_q, m_r, m_dbz;
    int p_q, p_r;

    always @(posedge clk) begin
        if (rst) begin
            model_ok = 1'b1;
            m_left = 0; m_busy = 0; m_done = 0; m_q = 0; m_r = 0; m_dbz = 0;
        end else if (m_left == 0 && start) begin
            m_done = 0;
            if (divisor == 0) begin
                m_q = (1 << DW) - 1; m_r = 0; m_dbz = 1; m_done = 1; m_busy = 0;
            end else begin
                p_q = int'(dividend) / int'(divisor);
                p_r = int'(dividend) % int'(divisor);
                m_left = DW; m_busy = 1; m_dbz = 0;
            end
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0; m_done = 1; m_q = p_q; m_r = p_r;
            end
        end else begin
            m_done = 0;
        end
    end

    // Every-cycle compare against the model; results only meaningful while not busy.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("busy", int'(busy), m_busy);
            chk("done", int'(done), m_done);
            if (m_busy == 0) begin
                chk("quotient", int'(quotient), m_q);
                chk("remainder", int'(remainder), m_r);
                chk("div_by_zero", int'(div_by_zero), m_dbz);
            end
        end
    end

    // Issue one op from a negedge; returns at the negedge where done is seen.
    // lat counts edges with the accepting edge as 1.
    task automatic do_op(input logic [DW-1:0] dvd, input logic [VW-1:0] dvs,
                         input bit noise, output int lat);
        start = 1'b1; dividend = dvd; divisor = dvs;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        start = 1'b0;
        while (!done && lat < 20) begin
            if (noise && $urandom_range(0, 2) == 0) begin
                start = 1'b1; dividend = DW'($urandom); divisor = VW'($urandom);
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic op_expect(input string name, input int dvd, input int dvs,
                             input int eq, input int er, input int edbz, input bit noise);
        int lat;
        do_op(DW'(dvd), VW'(dvs), noise, lat);
        chk({name, "_latency"}, lat, (dvs == 0) ? 1 : DW + 1);
        chk({name, "_q"}, int'(quotient), eq);
        chk({name, "_r"}, int'(remainder), er);
        chk({name, "_dbz"}, int'(div_by_zero), edbz);
    endtask

    initial begin
        int pulses, gq, gr, lat, dvd, dvs, busy_cycles;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_q", int'(quotient), 0);
        chk("reset_r", int'(remainder), 0);
        chk("reset_dbz", int'(div_by_zero), 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic timing with busy-width count.
        start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        busy_cycles = 0; lat = 1;
        while (!done && lat < 20) begin
            if (busy) busy_cycles++;
            @(posedge clk); lat++;
            @(negedge clk);
        end
        chk("basic_busy_cycles", busy_cycles, 8);
        chk("basic_latency", lat, 9);
        chk("basic_q", int'(quotient), 28);
        chk("basic_r", int'(remainder), 4);
        chk("basic_dbz", int'(div_by_zero), 0);
        chk("model_pin_q", m_q, 28);
        chk("model_pin_r", m_r, 4);
        @(negedge clk);

        // Boundaries.
        op_expect("b255_1", 255, 1, 255, 0, 0, 1'b0);
        op_expect("b5_15", 5, 15, 0, 5, 0, 1'b0);
        op_expect("b0_9", 0, 9, 0, 0, 0, 1'b0);
        op_expect("b255_15", 255, 15, 17, 0, 0, 1'b0);
        chk("model_pin_q17", m_q, 17);

        // Divide by zero then back-to-back normal op.
        @(negedge clk);
        op_expect("dz100_0", 100, 0, 255, 0, 1, 1'b0);
        chk("dz_busy", int'(busy), 0);
        op_expect("b2b100_3", 100, 3, 33, 1, 0, 1'b0);
        @(negedge clk);

        // start while busy is ignored.
        start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        pulses = 0; gq = -1; gr = -1;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 2) begin
                start = 1'b1; dividend = 8'd60; divisor = 4'd5;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                pulses++; gq = int'(quotient); gr = int'(remainder);
            end
        end
        chk("ignore_pulses", pulses, 1);
        chk("ignore_q", gq, 28);
        chk("ignore_r", gr, 4);

        // Reset mid-run.
        start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_q", int'(quotient), 0);
        chk("midrst_r", int'(remainder), 0);
        chk("midrst_dbz", int'(div_by_zero), 0);
        pulses = 0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (done) pulses++;
        end
        chk("midrst_no_done", pulses, 0);
        op_expect("after_rst77_6", 77, 6, 12, 5, 0, 1'b0);
        @(negedge clk);

        // Round trip of every 4x4 product.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0) op_expect("rt_zero", a * b, b, 255, 0, 1, 1'b0);
                else        op_expect("rt", a * b, b, a, 0, 0, 1'b0);
            end
        end

        // Random ops with noise on start during runs, random gaps and back-to-back.
        for (int i = 0; i < 200; i++) begin
            dvd = int'($urandom_range(0, 255));
            dvs = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15));
            if (dvs == 0) op_expect("rnd_zero", dvd, 0, 255, 0, 1, 1'b1);
            else          op_expect("rnd", dvd, dvs, dvd / dvs, dvd % dvs, 0, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
